dna_port_sequencer: RTL and testbench

//  Sequences the DNA_PORT primitive to read the 57-bit device DNA and presents it as a held

---
 rtl/dna_seq_pkg.sv | 18 +
 rtl/dna_port_sequencer_if.sv | 27 ++
 rtl/dna_clk_divider.sv | 46 ++++
 rtl/dna_port_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_dna_port_sequencer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dna_seq_pkg.sv
// Shared constants for the device-DNA sequencer: DNA width, bit-counter width
// and the FSM state encoding.
package dna_seq_pkg;

    localparam int DNA_WIDTH = 57;
    localparam int BIT_CNT_W = 6;

    typedef logic [2:0] seq_state_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DNA_WIDTH - 1);

endpackage

// File: rtl/dna_port_sequencer_if.sv
// Pin bundle between the sequencer and the DNA_PORT primitive.
// master = sequencer side, slave = primitive side.
interface dna_port_sequencer_if;

    logic dna_clk_o;
    logic dna_read_o;
    logic dna_shift_o;
    logic dna_din_o;
    logic dna_dout_i;

    modport master (
        output dna_clk_o,
        output dna_read_o,
        output dna_shift_o,
        output dna_din_o,
        input  dna_dout_i
    );

    modport slave (
        input  dna_clk_o,
        input  dna_read_o,
        input  dna_shift_o,
        input  dna_din_o,
        output dna_dout_i
    );

endinterface

// File: rtl/dna_clk_divider.sv
// DNA clock divider: toggles dna_clk_o every CLK_DIV cycles and flags the
// rising/falling toggles. clear_i holds the clock low and the counter at zero.
module dna_clk_divider #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic dna_clk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          clk_q, clk_d;
    logic          tick;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        clk_d = clk_q ^ tick;
        if (clear_i) begin
            cnt_d = '0;
            clk_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= clk_d;
        end
    end

    assign dna_clk_o = clk_q;
    assign rise_o    = tick & ~clk_q & ~clear_i;
    assign fall_o    = tick &  clk_q & ~clear_i;

endmodule

// File: rtl/dna_port_sequencer.sv
// Reads the 57-bit device DNA through DNA_PORT and holds it for the register slave.
// Define DNA_DOUBLE_READ_EN to read twice per start and flag differing results.
module dna_port_sequencer
    import dna_seq_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter bit AUTO_START = 1'b0
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 dna_valid_o,
    output logic [DNA_WIDTH-1:0] dna_o,
    output logic                 mismatch_o,
    output seq_state_t           state_o,
    dna_port_sequencer_if.master dna_if
);

    seq_state_t           state_q, state_d;
    logic                 read_q, read_d;
    logic                 shift_q, shift_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 loaded_q, loaded_d;
    logic                 auto_q, auto_d;
    logic [DNA_WIDTH-1:0] dna_q, dna_d;
    logic [DNA_WIDTH-1:0] sr_q, sr_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
`ifdef DNA_DOUBLE_READ_EN
    logic                 mismatch_q, mismatch_d;
    logic                 pass_q, pass_d;
    logic                 gap_q, gap_d;
    logic [DNA_WIDTH-1:0] first_q, first_d;
`endif

    logic div_clear, dna_clk, rise, fall;

    assign div_clear = !((state_q == ST_LOAD) || (state_q == ST_SHIFT));

    dna_clk_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clk       (ACLK),
        .rst       (ARESET),
        .clear_i   (div_clear),
        .dna_clk_o (dna_clk),
        .rise_o    (rise),
        .fall_o    (fall)
    );

    always_comb begin
        state_d   = state_q;
        read_d    = read_q;
        shift_d   = shift_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        loaded_d  = loaded_q;
        auto_d    = auto_q;
        dna_d     = dna_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
`ifdef DNA_DOUBLE_READ_EN
        mismatch_d = mismatch_q;
        pass_d     = pass_q;
        gap_d      = gap_q;
        first_d    = first_q;
`endif
        case (state_q)
            ST_IDLE: begin
                auto_d = 1'b0;
                if (start_i || auto_q) begin
                    read_d    = 1'b1;
                    valid_d   = 1'b0;
                    loaded_d  = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = ST_LOAD;
`ifdef DNA_DOUBLE_READ_EN
                    mismatch_d = 1'b0;
                    pass_d     = 1'b0;
                    gap_d      = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                // READ is sampled on the first rise; the fall after it presents bit 56.
                if (rise) loaded_d = 1'b1;
                if (fall && loaded_q) begin
                    sr_d      = {sr_q[DNA_WIDTH-2:0], dna_if.dna_dout_i};
                    read_d    = 1'b0;
                    shift_d   = 1'b1;
                    bit_cnt_d = BIT_CNT_W'(1);
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (fall) begin
                    sr_d      = {sr_q[DNA_WIDTH-2:0], dna_if.dna_dout_i};
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        shift_d = 1'b0;
`ifdef DNA_DOUBLE_READ_EN
                        state_d = pass_q ? ST_DONE : ST_GAP;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
`ifdef DNA_DOUBLE_READ_EN
            ST_GAP: begin
                // First cycle parks the first result, second re-enters LOAD like an IDLE exit.
                if (!gap_q) begin
                    first_d = sr_q;
                    gap_d   = 1'b1;
                end else begin
                    gap_d     = 1'b0;
                    pass_d    = 1'b1;
                    read_d    = 1'b1;
                    loaded_d  = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = ST_LOAD;
                end
            end
`endif
            ST_DONE: begin
                dna_d   = sr_q;
                valid_d = 1'b1;
                done_d  = 1'b1;
                state_d = ST_IDLE;
`ifdef DNA_DOUBLE_READ_EN
                mismatch_d = (first_q != sr_q);
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= ST_IDLE;
            read_q    <= 1'b0;
            shift_q   <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            loaded_q  <= 1'b0;
            auto_q    <= AUTO_START;
            dna_q     <= '0;
            sr_q      <= '0;
            bit_cnt_q <= '0;
`ifdef DNA_DOUBLE_READ_EN
            mismatch_q <= 1'b0;
            pass_q     <= 1'b0;
            gap_q      <= 1'b0;
            first_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            read_q    <= read_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            loaded_q  <= loaded_d;
            auto_q    <= auto_d;
            dna_q     <= dna_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
`ifdef DNA_DOUBLE_READ_EN
            mismatch_q <= mismatch_d;
            pass_q     <= pass_d;
            gap_q      <= gap_d;
            first_q    <= first_d;
`endif
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;
    assign dna_valid_o = valid_q;
    assign dna_o       = dna_q;
    assign state_o     = state_q;
`ifdef DNA_DOUBLE_READ_EN
    assign mismatch_o  = mismatch_q;
`else
    assign mismatch_o  = 1'b0;
`endif

    assign dna_if.dna_clk_o   = dna_clk;
    assign dna_if.dna_read_o  = read_q;
    assign dna_if.dna_shift_o = shift_q;
    assign dna_if.dna_din_o   = 1'b0;

endmodule

// File: tb/tb_dna_port_sequencer.sv
// Bench for dna_port_sequencer: DNA_PORT behavioural model, latency-level reference
// model with expected-value queue, per-cycle compare and directed scenarios.
module tb_dna_port_sequencer;
  import dna_seq_pkg::*;

  localparam int CLK_DIV = 4;
`ifdef DNA_DOUBLE_READ_EN
  localparam int NPASS   = 2;
  localparam int LAT     = 2 * (114 * CLK_DIV + 1) + 1;
  localparam int EXP_LAT = 915;
`else
  localparam int NPASS   = 1;
  localparam int LAT     = 114 * CLK_DIV + 1;
  localparam int EXP_LAT = 457;
`endif

  // ---------------- clock / reset ----------------
  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic rst_a = 1'b1;
  logic start = 1'b0;
  int   cyc = 0;

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  logic                 busy, done, valid, mis;
  logic [DNA_WIDTH-1:0] dna;
  seq_state_t           state;
  logic                 busy_a, done_a, valid_a, mis_a;
  logic [DNA_WIDTH-1:0] dna_a;
  seq_state_t           state_a;

  dna_port_sequencer_if m_if();
  dna_port_sequencer_if a_if();

  dna_port_sequencer #(.CLK_DIV(CLK_DIV), .AUTO_START(1'b0)) u_dut (
    .ACLK(ACLK), .ARESET(ARESET), .start_i(start), .busy_o(busy), .done_o(done),
    .dna_valid_o(valid), .dna_o(dna), .mismatch_o(mis), .state_o(state), .dna_if(m_if)
  );

  dna_port_sequencer #(.CLK_DIV(CLK_DIV), .AUTO_START(1'b1)) u_auto (
    .ACLK(ACLK), .ARESET(rst_a), .start_i(1'b0), .busy_o(busy_a), .done_o(done_a),
    .dna_valid_o(valid_a), .dna_o(dna_a), .mismatch_o(mis_a), .state_o(state_a), .dna_if(a_if)
  );

  // ---------------- DNA_PORT behavioural models ----------------
  logic [DNA_WIDTH-1:0] dna_val, dna_val2, m_sr, a_sr;
  int load_cnt = 0;

  always @(posedge m_if.dna_clk_o or posedge ARESET) begin
    if (ARESET) load_cnt <= 0;
    else if (m_if.dna_read_o) begin
      m_sr <= load_cnt[0] ? dna_val2 : dna_val;
      load_cnt <= load_cnt + 1;
    end else if (m_if.dna_shift_o) m_sr <= {m_sr[DNA_WIDTH-2:0], m_if.dna_din_o};
  end
  assign m_if.dna_dout_i = m_sr[DNA_WIDTH-1];

  always @(posedge a_if.dna_clk_o) begin
    if (a_if.dna_read_o) a_sr <= dna_val;
    else if (a_if.dna_shift_o) a_sr <= {a_sr[DNA_WIDTH-2:0], a_if.dna_din_o};
  end
  assign a_if.dna_dout_i = a_sr[DNA_WIDTH-1];

  // ---------------- reference model + scoreboard ----------------
  logic [DNA_WIDTH-1:0] exp_q[$];
  logic m_busy, m_done, m_valid, m_mis;
  logic [DNA_WIDTH-1:0] m_dna;
  int m_end;

  always @(posedge ACLK) begin
    if (ARESET) begin
      m_busy = 1'b0; m_done = 1'b0; m_valid = 1'b0; m_mis = 1'b0; m_dna = '0;
      exp_q.delete();
    end else if (!m_busy) begin
      m_done = 1'b0;
      if (start) begin
        m_busy = 1'b1; m_end = cyc + LAT; m_valid = 1'b0; m_mis = 1'b0;
        exp_q.push_back((NPASS == 2) ? dna_val2 : dna_val);
      end
    end else if (cyc == m_end) begin
      m_busy = 1'b0; m_done = 1'b1; m_valid = 1'b1;
      m_dna = exp_q.pop_front();
      m_mis = (NPASS == 2) && (dna_val != dna_val2);
    end else m_done = 1'b0;
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  int rise_cnt = 0, read_rise_cnt = 0, done_cnt = 0;
  logic clk_prev = 1'b0, read_prev = 1'b0, shift_prev = 1'b0;

  always @(negedge ACLK) begin
    if (chk_en) begin
      check("busy", 64'(busy), 64'(m_busy));
      check("done", 64'(done), 64'(m_done));
      check("valid", 64'(valid), 64'(m_valid));
      check("dna", 64'(dna), 64'(m_dna));
      check("mismatch", 64'(mis), 64'(m_mis));
      check("din", 64'(m_if.dna_din_o), 64'd0);
      if (m_if.dna_clk_o && !clk_prev) begin
        rise_cnt++;
        if (m_if.dna_read_o) read_rise_cnt++;
        check("ctl_at_rise", 64'({m_if.dna_read_o, m_if.dna_shift_o}), 64'({read_prev, shift_prev}));
      end
      if (done) done_cnt++;
    end
    clk_prev   = m_if.dna_clk_o;
    read_prev  = m_if.dna_read_o;
    shift_prev = m_if.dna_shift_o;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic set_dna(input logic [DNA_WIDTH-1:0] v);
    dna_val  = v;
    dna_val2 = v;
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1;
    tick(1);
    s = cyc - 1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int d);
    bit ok;
    ok = 1'b0;
    d = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick(1);
      if (done === 1'b1) begin
        d = cyc - 1;
        ok = 1'b1;
      end
    end
    if (!ok) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_valid"}, 64'(valid), 64'd0);
    check({tag, "_dna"}, 64'(dna), 64'd0);
    check({tag, "_mis"}, 64'(mis), 64'd0);
    check({tag, "_clk"}, 64'(m_if.dna_clk_o), 64'd0);
    check({tag, "_read"}, 64'(m_if.dna_read_o), 64'd0);
    check({tag, "_shift"}, 64'(m_if.dna_shift_o), 64'd0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int s, s2, d, d1, d2, r0, rr0, dc0, k;
    bit seen;

    set_dna(57'h1_2345_6789_ABCD_EF);
    tick(3);
    check_all_zero("reset");
    chk_en = 1'b1;
    ARESET = 1'b0;
    tick(2);

    // single read: value, latency, one-cycle done, rise counts
    r0 = rise_cnt; rr0 = read_rise_cnt; dc0 = done_cnt;
    pulse_start(s);
    wait_done(2000, d);
    check("t1_latency", 64'(d - s), 64'(EXP_LAT));
    check("t1_dna", 64'(dna), 64'h1_2345_6789_ABCD_EF);
    check("t1_valid", 64'(valid), 64'd1);
    check("t1_mis", 64'(mis), 64'd0);
    tick(1);
    check("t1_done_one_cycle", 64'(done), 64'd0);
    check("t1_valid_hold", 64'(valid), 64'd1);
    check("t2_rises", 64'(rise_cnt - r0), 64'(57 * NPASS));
    check("t2_read_rises", 64'(read_rise_cnt - rr0), 64'(NPASS));
    check("t1_done_count", 64'(done_cnt - dc0), 64'd1);

    // start while busy is ignored
    set_dna(57'h0_A5A5_5A5A_0F0F_3C);
    dc0 = done_cnt;
    pulse_start(s);
    tick(289);
    pulse_start(s2);
    check("t3_second_at_290", 64'(s2 - s), 64'd290);
    wait_done(2000, d);
    check("t3_latency", 64'(d - s), 64'(EXP_LAT));
    check("t3_dna", 64'(dna), 64'h0_A5A5_5A5A_0F0F_3C);
    tick(LAT + 20);
    check("t3_single_done", 64'(done_cnt - dc0), 64'd1);
    check("t3_idle", 64'(busy), 64'd0);

    // start held high: back-to-back reads, one IDLE cycle between
    start = 1'b1;
    wait_done(2000, d1);
    tick(1);
    check("t3_rearm_busy", 64'(busy), 64'd1);
    check("t3_rearm_valid", 64'(valid), 64'd0);
    start = 1'b0;
    wait_done(2000, d2);
    check("t3_b2b_spacing", 64'(d2 - d1), 64'(EXP_LAT + 1));

    // reset mid-SHIFT aborts with no done, then a fresh read works
    set_dna(57'h1_FFFF_0000_1234_56);
    pulse_start(s);
    tick(199);
    ARESET = 1'b1;
    tick(1);
    check_all_zero("t4_abort");
    ARESET = 1'b0;
    dc0 = done_cnt;
    tick(LAT + 20);
    check("t4_no_done", 64'(done_cnt - dc0), 64'd0);
    pulse_start(s);
    wait_done(2000, d);
    check("t4_latency", 64'(d - s), 64'(EXP_LAT));
    check("t4_dna", 64'(dna), 64'h1_FFFF_0000_1234_56);

`ifdef DNA_DOUBLE_READ_EN
    // second pass differs in bit 0
    dna_val  = 57'h0_1357_9BDF_2468_AC;
    dna_val2 = 57'h0_1357_9BDF_2468_AD;
    pulse_start(s);
    wait_done(3000, d);
    check("t6_latency", 64'(d - s), 64'd915);
    check("t6_mis", 64'(mis), 64'd1);
    check("t6_dna_second", 64'(dna), 64'h0_1357_9BDF_2468_AD);
    set_dna(57'h0_1357_9BDF_2468_AC);
    pulse_start(s);
    check("t6_mis_clear", 64'(mis), 64'd0);
    wait_done(3000, d);
    check("t6_same_mis", 64'(mis), 64'd0);
    check("t6_same_dna", 64'(dna), 64'h0_1357_9BDF_2468_AC);
`endif

    // auto start after reset release
    set_dna(57'h1_0F1E_2D3C_4B5A_69);
    check("t5_rst_valid", 64'(valid_a), 64'd0);
    rst_a = 1'b0;
    seen = 1'b0;
    k = 0;
    for (int i = 1; i <= 3000 && !seen; i++) begin
      tick(1);
      if (valid_a === 1'b1) begin
        seen = 1'b1;
        k = i;
      end
    end
    check("t5_seen", 64'(seen), 64'd1);
    check("t5_latency", 64'(k - 1), 64'(EXP_LAT));
    check("t5_dna", 64'(dna_a), 64'h1_0F1E_2D3C_4B5A_69);
    check("t5_done", 64'(done_a), 64'd1);

    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete at t=%0t", $time);
    $fatal(1, "global timeout");
  end

endmodule
